// File: rtl/simd_muland_stream_pkg.sv
// Shared types and mask helpers for the lane-segmented SIMD multiply/AND stream unit.
package simd_muland_stream_pkg;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_LIMB_W = 32;
    localparam int DEF_TAG_W  = 8;
    localparam int MAX_NLIMB  = 64;

    typedef struct packed {
        logic b;
    } mode_t;

    typedef logic [2:0] lane_log_t;

    typedef struct packed {
        logic                 valid;
        mode_t                mode;
        lane_log_t            lane;
        logic [DEF_TAG_W-1:0] tag;
    } beat_ctl_t;

    // AND beats run as one full-width lane; oversized lane codes saturate to full width.
    function automatic lane_log_t eff_lane(input logic mode_b, input lane_log_t lane, input int nlimb);
        lane_log_t lmax;
        lmax = lane_log_t'($clog2(nlimb));
        if (mode_b || (lane > lmax)) begin
            return lmax;
        end else begin
            return lane;
        end
    endfunction

    // Bit c set when a carry out of limb c may enter limb c+1.
    function automatic logic [MAX_NLIMB-1:0] make_carry_mask(input lane_log_t lane, input int data_w, input int limb_w);
        logic [MAX_NLIMB-1:0] m;
        int n;
        int span;
        m    = '0;
        n    = data_w / limb_w;
        span = 32'sd1 << lane;
        for (int c = 0; c < MAX_NLIMB; c++) begin
            m[c] = ((c + 1) < n) && (((c + 1) % span) != 0);
        end
        return m;
    endfunction

    function automatic logic make_lane_mask(input int row, input int col, input lane_log_t lane);
        return (row >> lane) == (col >> lane);
    endfunction

endpackage

// File: rtl/muland_limb_stage.sv
// One accumulation row: limb partial product, lane shift/mask, carry-save add, held row register.
module muland_limb_stage
    import simd_muland_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LIMB_W = DEF_LIMB_W,
    parameter int ROW    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  beat_ctl_t         ctl_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [DATA_W-1:0] sum_i,
    input  logic [DATA_W-1:0] carry_i,
    output beat_ctl_t         ctl_o,
    output logic [DATA_W-1:0] x_o,
    output logic [DATA_W-1:0] y_o,
    output logic [DATA_W-1:0] sum_o,
    output logic [DATA_W-1:0] carry_o
);
    localparam int NLIMB = DATA_W / LIMB_W;

    lane_log_t         lane_s;
    int                lo_s;
    logic [DATA_W-1:0] lane_m_s, kill_s, y_ext_s, pp_s, maj_s;
    beat_ctl_t         ctl_d, ctl_q;
    logic [DATA_W-1:0] x_d, x_q, y_d, y_q, sum_d, sum_q, carry_d, carry_q;

    // Partial product of Y limb ROW confined to its own lane, folded into the carry-save pair.
    always_comb begin
        lane_s   = eff_lane(ctl_i.mode.b, ctl_i.lane, NLIMB);
        lo_s     = (ROW >> lane_s) << lane_s;
        lane_m_s = '0;
        kill_s   = '1;
        for (int c = 0; c < NLIMB; c++) begin
            lane_m_s[c*LIMB_W +: LIMB_W] = {LIMB_W{make_lane_mask(ROW, c, lane_s)}};
            if ((c > 0) && !make_lane_mask(c - 1, c, lane_s)) begin
                kill_s[c*LIMB_W] = 1'b0;
            end else begin
                kill_s[c*LIMB_W] = 1'b1;
            end
        end
        y_ext_s               = '0;
        y_ext_s[LIMB_W-1:0]   = y_i[ROW*LIMB_W +: LIMB_W];
        pp_s  = (((x_i & lane_m_s) * y_ext_s) << ((ROW - lo_s) * LIMB_W)) & lane_m_s;
        maj_s = (sum_i & carry_i) | (sum_i & pp_s) | (carry_i & pp_s);
        if (hold_i) begin
            ctl_d   = ctl_q;
            x_d     = x_q;
            y_d     = y_q;
            sum_d   = sum_q;
            carry_d = carry_q;
        end else begin
            ctl_d   = ctl_i;
            x_d     = x_i;
            y_d     = y_i;
            sum_d   = sum_i ^ carry_i ^ pp_s;
            carry_d = (maj_s << 1) & kill_s;
        end
    end

    // Row control register; reset clears the beat valid bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctl_q <= '0;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    // Row datapath register.
    always_ff @(posedge clk_i) begin
        x_q     <= x_d;
        y_q     <= y_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
    end

    assign ctl_o   = ctl_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/simd_muland_stream.sv
// Flow-controlled SIMD lane multiply / bitwise AND: capture stage, NLIMB carry-save rows, segmented CPA.
module simd_muland_stream
    import simd_muland_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LIMB_W = DEF_LIMB_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  mode_t             mode_i,
    input  lane_log_t         lane_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] z_o,
    output logic [TAG_W-1:0]  tag_o
);
    localparam int NLIMB = DATA_W / LIMB_W;

    logic              stall_s;
    beat_ctl_t         ctl0_d, ctl0_q;
    logic [DATA_W-1:0] x0_d, x0_q, y0_d, y0_q;
    beat_ctl_t         ctl_s   [0:NLIMB];
    logic [DATA_W-1:0] x_s     [0:NLIMB];
    logic [DATA_W-1:0] y_s     [0:NLIMB];
    logic [DATA_W-1:0] sum_s   [0:NLIMB];
    logic [DATA_W-1:0] carry_s [0:NLIMB];
    lane_log_t         lane_out_s;
    logic [NLIMB-1:0]  cm_s;
    logic              cin_s;
    logic [LIMB_W:0]   acc_s;
    logic [DATA_W-1:0] z_cpa_s;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] z_d, z_q;
    logic [TAG_W-1:0]  tag_d, tag_q;

    assign stall_s    = out_valid_q && !out_ready_i;
    assign in_ready_o = !rst_i && !stall_s;

    // Capture stage; AND is recast as (x & y) * 1 so both modes share the multiplier path.
    always_comb begin
        if (stall_s) begin
            ctl0_d = ctl0_q;
            x0_d   = x0_q;
            y0_d   = y0_q;
        end else begin
            ctl0_d.valid = in_valid_i;
            ctl0_d.mode  = mode_i;
            ctl0_d.lane  = lane_i;
            ctl0_d.tag   = tag_i;
            x0_d = mode_i.b ? (x_i & y_i) : x_i;
            y0_d = mode_i.b ? {{(DATA_W-1){1'b0}}, 1'b1} : y_i;
        end
    end

    // Capture control register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctl0_q <= '0;
        end else begin
            ctl0_q <= ctl0_d;
        end
    end

    // Capture operand register.
    always_ff @(posedge clk_i) begin
        x0_q <= x0_d;
        y0_q <= y0_d;
    end

    assign ctl_s[0]   = ctl0_q;
    assign x_s[0]     = x0_q;
    assign y_s[0]     = y0_q;
    assign sum_s[0]   = '0;
    assign carry_s[0] = '0;

    genvar r;
    for (r = 0; r < NLIMB; r++) begin : g_row
        muland_limb_stage #(
            .DATA_W(DATA_W),
            .LIMB_W(LIMB_W),
            .ROW   (r)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .hold_i (stall_s),
            .ctl_i  (ctl_s[r]),
            .x_i    (x_s[r]),
            .y_i    (y_s[r]),
            .sum_i  (sum_s[r]),
            .carry_i(carry_s[r]),
            .ctl_o  (ctl_s[r+1]),
            .x_o    (x_s[r+1]),
            .y_o    (y_s[r+1]),
            .sum_o  (sum_s[r+1]),
            .carry_o(carry_s[r+1])
        );
    end

    // Limb-serial carry-propagate add with carries dropped at lane boundaries.
    always_comb begin
        lane_out_s = eff_lane(ctl_s[NLIMB].mode.b, ctl_s[NLIMB].lane, NLIMB);
        cm_s       = NLIMB'(make_carry_mask(lane_out_s, DATA_W, LIMB_W));
        cin_s      = 1'b0;
        acc_s      = '0;
        z_cpa_s    = '0;
        for (int c = 0; c < NLIMB; c++) begin
            acc_s = {1'b0, sum_s[NLIMB][c*LIMB_W +: LIMB_W]}
                  + {1'b0, carry_s[NLIMB][c*LIMB_W +: LIMB_W]}
                  + {{LIMB_W{1'b0}}, cin_s};
            z_cpa_s[c*LIMB_W +: LIMB_W] = acc_s[LIMB_W-1:0];
            cin_s = acc_s[LIMB_W] & cm_s[c];
        end
        if (stall_s) begin
            out_valid_d = out_valid_q;
            z_d         = z_q;
            tag_d       = tag_q;
        end else if (ctl_s[NLIMB].valid) begin
            out_valid_d = 1'b1;
            z_d         = z_cpa_s;
            tag_d       = ctl_s[NLIMB].tag;
        end else begin
            out_valid_d = 1'b0;
            z_d         = z_q;
            tag_d       = tag_q;
        end
    end

    // Output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign z_o         = z_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_simd_muland_stream.sv
// Self-checking bench: directed vector table, latency/backpressure/reset sequences, random soak vs lane model.
module tb_simd_muland_stream;
    import simd_muland_stream_pkg::*;

    localparam int DW = 256;
    localparam int TW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] x_i = '0;
    logic [DW-1:0] y_i = '0;
    mode_t         mode_i = '0;
    lane_log_t     lane_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] z_o;
    logic [TW-1:0] tag_o;

    always #5 clk_i = ~clk_i;

    simd_muland_stream #(.DATA_W(DW), .LIMB_W(32), .TAG_W(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x_i(x_i), .y_i(y_i), .mode_i(mode_i), .lane_i(lane_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .z_o(z_o), .tag_o(tag_o)
    );

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          mb;
        logic [2:0]    lane;
        logic [TW-1:0] tag;
        logic [DW-1:0] z;
    } vec_t;

    vec_t          tbl [10];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_push = 0;
    logic [DW-1:0] exp_z_q [$];
    logic [TW-1:0] exp_t_q [$];

    function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic mb, input logic [2:0] lane);
        logic [DW-1:0] z, m, xl, yl;
        int            l, w;
        if (mb) return x & y;
        l = (lane > 3'd3) ? 3 : int'(lane);
        w = 32 << l;
        m = (w == DW) ? {DW{1'b1}} : ((256'd1 << w) - 256'd1);
        z = '0;
        for (int b = 0; b < DW; b += w) begin
            xl = (x >> b) & m;
            yl = (y >> b) & m;
            z  = z | (((xl * yl) & m) << b);
        end
        return z;
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: score output handshake, record accepted beat, advance to next negedge.
    task automatic step(input logic [DW-1:0] exp_z);
        #1;
        if (out_valid_o && out_ready_i) begin
            if (exp_z_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_output: got z=%h tag=%h expected no beat", z_o, tag_o);
            end else begin
                check("z", z_o, exp_z_q.pop_front());
                check("tag", DW'(tag_o), DW'(exp_t_q.pop_front()));
            end
        end
        if (in_valid_i && in_ready_o) begin
            exp_z_q.push_back(exp_z);
            exp_t_q.push_back(tag_i);
            n_push++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_vec(input vec_t v);
        in_valid_i = 1'b1;
        x_i = v.x; y_i = v.y; mode_i.b = v.mb; lane_i = v.lane; tag_i = v.tag;
    endtask

    task automatic rand_beat(output logic [DW-1:0] e);
        in_valid_i = 1'b1;
        x_i = rand256(); y_i = rand256();
        mode_i.b = ($urandom_range(0, 3) == 0);
        lane_i = 3'($urandom_range(0, 7));
        tag_i = 8'($urandom);
        e = model(x_i, y_i, mode_i.b, lane_i);
    endtask

    task automatic drain(input int bound);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < bound && exp_z_q.size() > 0; i++) step('0);
        check("drain_empty", DW'(exp_z_q.size()), '0);
    endtask

    task automatic latency_run(input vec_t v, input string name);
        int cnt;
        out_ready_i = 1'b1;
        drive_vec(v);
        step(v.z);
        in_valid_i = 1'b0;
        cnt = 0;
        while (!out_valid_o && cnt < 20) begin
            step('0);
            cnt++;
        end
        check(name, DW'(cnt), DW'(9));
        step('0);
    endtask

    initial begin
        logic [DW-1:0] e, held_z;
        logic [TW-1:0] held_t;
        int            cyc, start;

        tbl[0] = '{{8{32'hFFFF_FFFF}}, {8{32'hFFFF_FFFF}}, 1'b0, 3'd0, 8'h10, {8{32'h0000_0001}}};
        tbl[1] = '{{128'h1, 128'h0}, {128'h1, 128'h0}, 1'b0, 3'd3, 8'h11, 256'd0};
        tbl[2] = '{{128'h1, 128'h3}, 256'd5, 1'b0, 3'd3, 8'h12, {128'h5, 128'hF}};
        tbl[3] = '{{4{64'h1_0000_0000}}, {4{64'h1_0000_0000}}, 1'b0, 3'd1, 8'h13, 256'd0};
        tbl[4] = '{{2{128'h1_0000_0000_0000_0000}}, {2{128'd3}}, 1'b0, 3'd2, 8'h14,
                   {2{128'h3_0000_0000_0000_0000}}};
        tbl[5] = '{{32{8'hF0}}, {16{16'hFF00}}, 1'b1, 3'd0, 8'h15, {16{16'hF000}}};
        tbl[6] = '{{4{64'h0123_4567_89AB_CDEF}}, {4{64'hFFFF_0000_FFFF_0000}}, 1'b1, 3'd2, 8'h16,
                   {4{64'h0123_0000_89AB_0000}}};
        tbl[7] = '{{128'h1, 128'h0}, {128'h1, 128'h0}, 1'b0, 3'd7, 8'h17, 256'd0};
        tbl[8] = '{{8{32'h0001_0000}}, {8{32'h0001_0000}}, 1'b0, 3'd0, 8'h18, 256'd0};
        tbl[9] = '{{4{64'hFFFF_FFFF_FFFF_FFFF}}, {4{64'h2}}, 1'b0, 3'd1, 8'h19,
                   {4{64'hFFFF_FFFF_FFFF_FFFE}}};

        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_in_ready", DW'(in_ready_o), '0);
        check("rst_out_valid", DW'(out_valid_o), '0);
        check("rst_z", z_o, '0);
        check("rst_tag", DW'(tag_o), '0);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", DW'(in_ready_o), DW'(1));

        latency_run(tbl[0], "latency_first");

        // Back-to-back mixed stream from the table.
        for (int i = 0; i < 10; i++) begin
            drive_vec(tbl[i]);
            step(tbl[i].z);
        end
        drain(30);

        // Backpressure: fill with consumer blocked, hold for 5 cycles, then drain.
        out_ready_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rand_beat(e);
            step(e);
        end
        check("bp_out_valid", DW'(out_valid_o), DW'(1));
        held_z = z_o;
        held_t = tag_o;
        for (int i = 0; i < 5; i++) begin
            rand_beat(e);
            #1;
            check("bp_in_ready", DW'(in_ready_o), '0);
            check("bp_z_stable", z_o, held_z);
            check("bp_tag_stable", DW'(tag_o), DW'(held_t));
            step(e);
        end
        drain(40);

        // Random-ready soak.
        start = n_push;
        cyc = 0;
        while ((n_push - start) < 10000 && cyc < 60000) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                rand_beat(e);
            end else begin
                in_valid_i = 1'b0;
                e = '0;
            end
            step(e);
            cyc++;
        end
        check("soak_beats", DW'(n_push - start), DW'(10000));
        drain(100);

        // Reset with beats in flight.
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_beat(e);
            step(e);
        end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("pulse_in_ready", DW'(in_ready_o), '0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_z_q.delete();
        exp_t_q.delete();
        for (int i = 0; i < 15; i++) begin
            check("post_rst_valid", DW'(out_valid_o), '0);
            step('0);
        end
        latency_run(tbl[2], "latency_after_rst");
        drain(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
